// File: rtl/sram_fb_writer.sv
// Framebuffer write engine: queues pixel writes and issues 3-cycle SRAM write
// cycles (setup/strobe/hold) only inside display-granted bus windows; also fills the screen.
module sram_fb_writer #(
  parameter int WIDTH      = 320,
  parameter int HEIGHT     = 240,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [8:0]  req_x,
  input  logic [8:0]  req_y,
  input  logic [15:0] req_color,
  input  logic        clear_start,
  input  logic [15:0] clear_color,
  input  logic        wr_allow,
  output logic [17:0] sram_addr,
  output logic [15:0] sram_dq_out,
  output logic        sram_dq_oe,
  output logic        sram_we_n,
  output logic        busy,
  output logic        clear_done,
  output logic [7:0]  dropped_count
);

  localparam int          AW       = $clog2(FIFO_DEPTH);
  localparam logic [17:0] W18      = 18'(WIDTH);
  localparam logic [17:0] H18      = 18'(HEIGHT);
  localparam logic [17:0] LAST     = 18'(WIDTH * HEIGHT - 1);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE, SETUP, STROBE, HOLD, CLR_SETUP, CLR_STROBE, CLR_HOLD
  } state_t;

  state_t        state;
  logic [17:0]   fifo_addr  [FIFO_DEPTH];
  logic [14:0]   fifo_color [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          started, clear_active;
  logic [17:0]   clr_addr;
  logic [14:0]   clr_color;
  logic          empty, full, accept, in_range, push, pop;
  logic [17:0]   req_addr;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign empty     = (count == '0);
  assign full      = (count == FULL_CNT);
  assign req_ready = started && !full && !clear_active;
  assign accept    = req_valid && req_ready;
  assign in_range  = (18'(req_x) < W18) && (18'(req_y) < H18);
  assign req_addr  = 18'(req_y) * W18 + 18'(req_x);
  // A clear_start in the same cycle flushes, so it also cancels a concurrent push/pop.
  assign push      = accept && in_range && !clear_start;
  assign pop       = (state == IDLE) && wr_allow && !clear_active && !empty && !clear_start;
  assign busy      = !empty || clear_active || (state != IDLE);

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr]  <= req_addr;
      fifo_color[wr_ptr] <= req_color[14:0];
    end
    if (clear_start) clr_color <= clear_color[14:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      started       <= 1'b0;
      dropped_count <= 8'd0;
    end else begin
      started <= 1'b1;
      if (accept && !in_range) dropped_count <= sat_inc(dropped_count);
      if (clear_start) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        case ({push, pop})
          2'b10:   count <= count + (AW + 1)'(1);
          2'b01:   count <= count - (AW + 1)'(1);
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      sram_we_n    <= 1'b1;
      sram_dq_oe   <= 1'b0;
      sram_addr    <= 18'd0;
      sram_dq_out  <= 16'd0;
      clear_active <= 1'b0;
      clear_done   <= 1'b0;
      clr_addr     <= 18'd0;
    end else begin
      clear_done <= 1'b0;
      case (state)
        IDLE: begin
          if (clear_active && wr_allow && !clear_start) begin
            state       <= CLR_SETUP;
            sram_addr   <= clr_addr;
            sram_dq_out <= {1'b0, clr_color};
            sram_dq_oe  <= 1'b1;
          end else if (pop) begin
            state       <= SETUP;
            sram_addr   <= fifo_addr[rd_ptr];
            sram_dq_out <= {1'b0, fifo_color[rd_ptr]};
            sram_dq_oe  <= 1'b1;
          end
        end
        SETUP:      begin state <= STROBE;     sram_we_n <= 1'b0; end
        STROBE:     begin state <= HOLD;       sram_we_n <= 1'b1; end
        HOLD:       begin state <= IDLE;       sram_dq_oe <= 1'b0; end
        CLR_SETUP:  begin state <= CLR_STROBE; sram_we_n <= 1'b0; end
        CLR_STROBE: begin state <= CLR_HOLD;   sram_we_n <= 1'b1; end
        CLR_HOLD: begin
          state      <= IDLE;
          sram_dq_oe <= 1'b0;
          if (clr_addr == LAST) begin
            clear_active <= 1'b0;
            clear_done   <= 1'b1;
          end else begin
            clr_addr <= clr_addr + 18'd1;
          end
        end
        default: state <= IDLE;
      endcase
      // A new clear overrides any completion or increment from the current cycle.
      if (clear_start) begin
        clear_active <= 1'b1;
        clr_addr     <= 18'd0;
        clear_done   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sram_fb_writer.sv
// Bench for sram_fb_writer: vector table plus hand sequences, with a write scoreboard
// fed at stimulus time and drained by a strobe monitor.
module tb_sram_fb_writer;

  localparam int W    = 320;
  localparam int H    = 4;
  localparam int NPIX = W * H;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [8:0]  req_x = '0;
  logic [8:0]  req_y = '0;
  logic [15:0] req_color = '0;
  logic        clear_start = 1'b0;
  logic [15:0] clear_color = '0;
  logic        wr_allow = 1'b0;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out;
  logic        sram_dq_oe;
  logic        sram_we_n;
  logic        busy;
  logic        clear_done;
  logic [7:0]  dropped_count;

  sram_fb_writer #(.WIDTH(W), .HEIGHT(H), .FIFO_DEPTH(8)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_color(req_color),
    .clear_start(clear_start), .clear_color(clear_color), .wr_allow(wr_allow),
    .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
    .sram_we_n(sram_we_n), .busy(busy), .clear_done(clear_done),
    .dropped_count(dropped_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [17:0] addr;
    logic [15:0] data;
  } wr_t;

  typedef struct {
    logic [8:0]  x;
    logic [8:0]  y;
    logic [15:0] color;
    bit          drop;
    logic [17:0] exp_addr;
    logic [15:0] exp_data;
  } vec_t;

  wr_t exp_q[$];
  int  strobe_cyc[$];
  int  total = 0;
  int  bad = 0;
  int  cyc = 0;
  int  done_n = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (clear_done) done_n++;
      if (!sram_we_n) begin
        strobe_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_strobe: got addr %0d data %0h, expected no write",
                   sram_addr, sram_dq_out);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          check("strobe_addr", 32'(sram_addr), 32'(e.addr));
          check("strobe_data", 32'(sram_dq_out), 32'(e.data));
          check("strobe_oe", 32'(sram_dq_oe), 1);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_wr(input int addr, input logic [15:0] data);
    wr_t e;
    e.addr = 18'(addr);
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic push(input logic [8:0] x, input logic [8:0] y, input logic [15:0] c);
    bit ok = 1'b0;
    req_x = x; req_y = y; req_color = c; req_valid = 1'b1;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = req_ready;
      step();
    end
    req_valid = 1'b0;
    check("push_accept", 32'(ok), 1);
  endtask

  task automatic wait_idle(input int maxc);
    bit done = 1'b0;
    for (int i = 0; i < maxc && !done; i++) begin
      @(negedge clk);
      done = !busy && (exp_q.size() == 0);
      step();
    end
    check("wait_idle", 32'(done), 1);
  endtask

  vec_t vecs[8];
  int   exp_drop;

  initial begin
    vecs[0] = '{x: 9'd5,   y: 9'd2,   color: 16'h7FFF, drop: 0, exp_addr: 18'd645,  exp_data: 16'h7FFF};
    vecs[1] = '{x: 9'd0,   y: 9'd0,   color: 16'h1234, drop: 0, exp_addr: 18'd0,    exp_data: 16'h1234};
    vecs[2] = '{x: 9'd319, y: 9'd3,   color: 16'hFFFF, drop: 0, exp_addr: 18'd1279, exp_data: 16'h7FFF};
    vecs[3] = '{x: 9'd320, y: 9'd0,   color: 16'h0001, drop: 1, exp_addr: 18'd0,    exp_data: 16'h0000};
    vecs[4] = '{x: 9'd0,   y: 9'd240, color: 16'h0002, drop: 1, exp_addr: 18'd0,    exp_data: 16'h0000};
    vecs[5] = '{x: 9'd0,   y: 9'd4,   color: 16'h0003, drop: 1, exp_addr: 18'd0,    exp_data: 16'h0000};
    vecs[6] = '{x: 9'd511, y: 9'd511, color: 16'h0004, drop: 1, exp_addr: 18'd0,    exp_data: 16'h0000};
    vecs[7] = '{x: 9'd100, y: 9'd1,   color: 16'h8001, drop: 0, exp_addr: 18'd420,  exp_data: 16'h0001};

    // Reset state
    #12;
    check("rst_we_n", 32'(sram_we_n), 1);
    check("rst_oe", 32'(sram_dq_oe), 0);
    check("rst_addr", 32'(sram_addr), 0);
    check("rst_dq", 32'(sram_dq_out), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(clear_done), 0);
    check("rst_dropped", 32'(dropped_count), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("ready_before_edge", 32'(req_ready), 0);
    @(negedge clk);
    check("ready_after_edge", 32'(req_ready), 1);
    step();

    // Single write with cycle-exact timing
    wr_allow = 1'b1;
    expect_wr(645, 16'h7FFF);
    push(9'd5, 9'd2, 16'h7FFF);
    @(negedge clk);
    check("t0_busy", 32'(busy), 1);
    check("t0_oe", 32'(sram_dq_oe), 0);
    step();
    @(negedge clk);
    check("t1_oe", 32'(sram_dq_oe), 1);
    check("t1_we_n", 32'(sram_we_n), 1);
    check("t1_addr", 32'(sram_addr), 645);
    check("t1_dq", 32'(sram_dq_out), 32'h7FFF);
    step();
    @(negedge clk);
    check("t2_we_n", 32'(sram_we_n), 0);
    step();
    @(negedge clk);
    check("t3_we_n", 32'(sram_we_n), 1);
    check("t3_oe", 32'(sram_dq_oe), 1);
    step();
    @(negedge clk);
    check("t4_oe", 32'(sram_dq_oe), 0);
    check("t4_we_n", 32'(sram_we_n), 1);
    step();

    // Vector table
    exp_drop = 0;
    foreach (vecs[i]) begin
      if (!vecs[i].drop) expect_wr(int'(vecs[i].exp_addr), vecs[i].exp_data);
      else exp_drop++;
      push(vecs[i].x, vecs[i].y, vecs[i].color);
      wait_idle(50);
      check("vec_dropped", 32'(dropped_count), exp_drop);
    end

    // Saturating drop counter
    for (int i = 0; i < 300; i++) push(9'd320, 9'd0, 16'h0);
    step();
    check("dropped_sat", 32'(dropped_count), 255);

    // Gated bus: nothing written until the grant, then FIFO order every 4 cycles
    wr_allow = 1'b0;
    for (int k = 0; k < 3; k++) begin
      expect_wr(320 + 10 + k, 16'(k + 1));
      push(9'(10 + k), 9'd1, 16'(k + 1));
    end
    strobe_cyc.delete();
    repeat (20) step();
    @(negedge clk);
    check("gated_no_strobe", strobe_cyc.size(), 0);
    check("gated_busy", 32'(busy), 1);
    step();
    wr_allow = 1'b1;
    wait_idle(100);
    check("gated_count", strobe_cyc.size(), 3);
    if (strobe_cyc.size() == 3) begin
      check("gated_gap1", strobe_cyc[1] - strobe_cyc[0], 4);
      check("gated_gap2", strobe_cyc[2] - strobe_cyc[1], 4);
    end

    // Full FIFO and back-pressure release after one pop
    wr_allow = 1'b0;
    for (int k = 0; k < 8; k++) begin
      expect_wr(k, 16'h0100 + 16'(k));
      push(9'(k), 9'd0, 16'h0100 + 16'(k));
    end
    @(negedge clk);
    check("full_ready", 32'(req_ready), 0);
    step();
    expect_wr(8, 16'h0108);
    req_x = 9'd8; req_y = 9'd0; req_color = 16'h0108; req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("full_held", 32'(req_ready), 0);
      step();
    end
    wr_allow = 1'b1;
    step();
    wr_allow = 1'b0;
    @(negedge clk);
    check("full_release", 32'(req_ready), 1);
    step();
    req_valid = 1'b0;
    @(negedge clk);
    check("full_again", 32'(req_ready), 0);
    step();
    wr_allow = 1'b1;
    wait_idle(300);

    // Clear flushes queued writes and fills every address
    wr_allow = 1'b0;
    push(9'd50, 9'd2, 16'h0AAA);
    push(9'd51, 9'd2, 16'h0BBB);
    clear_color = 16'h801F;
    clear_start = 1'b1;
    step();
    clear_start = 1'b0;
    clear_color = 16'h0000;
    @(negedge clk);
    check("clr_ready", 32'(req_ready), 0);
    check("clr_busy", 32'(busy), 1);
    step();
    for (int a = 0; a < NPIX; a++) expect_wr(a, 16'h001F);
    done_n = 0;
    wr_allow = 1'b1;
    wait_idle(NPIX * 4 + 200);
    repeat (3) step();
    check("clr_done_pulses", done_n, 1);
    check("clr_left", exp_q.size(), 0);
    @(negedge clk);
    check("clr_ready_back", 32'(req_ready), 1);
    step();

    // Asynchronous reset in the middle of a strobe
    wr_allow = 1'b0;
    expect_wr(327, 16'h0ABC);
    push(9'd7, 9'd1, 16'h0ABC);
    push(9'd8, 9'd1, 16'h0DEF);
    wr_allow = 1'b1;
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
        @(negedge clk);
        seen = !sram_we_n;
        if (!seen) step();
      end
      check("rst_strobe_seen", 32'(seen), 1);
    end
    #1 rst = 1'b1;
    #1;
    check("arst_we_n", 32'(sram_we_n), 1);
    check("arst_oe", 32'(sram_dq_oe), 0);
    check("arst_addr", 32'(sram_addr), 0);
    check("arst_dropped", 32'(dropped_count), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) step();
    @(negedge clk);
    check("post_rst_busy", 32'(busy), 0);
    check("post_rst_dropped", 32'(dropped_count), 0);
    check("post_rst_ready", 32'(req_ready), 1);
    check("post_rst_queue", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
